// File: rtl/retire_buffer_pkg.sv
// Shared types for the retire stage: ROB retire packet, queued entry, and a
// small helper telling whether a queued entry produces a register write.
package retire_buffer_pkg;

  localparam int XLEN = 32;
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [4:0]      r;
    logic [XLEN-1:0] V;
  } DATA_RETIRED;

  typedef struct packed {
    DATA_RETIRED data_retired;
  } ROB_RT_PACKET;

  localparam int RT_PACKET_W = $bits(ROB_RT_PACKET);

  typedef struct packed {
    logic [4:0]      r;
    logic [XLEN-1:0] V;
    logic            halt;
  } RT_ENTRY;

  localparam int RT_ENTRY_W = $bits(RT_ENTRY);

  function automatic logic writes_reg(input RT_ENTRY e);
    return (e.r != ZERO_REG) && !e.halt;
  endfunction

endpackage

// File: rtl/retire_fifo.sv
// Multi-push / multi-pop circular queue of retire entries. Valid push slots are
// compacted in slot order; the caller decides how many head entries leave.
module retire_fifo
  import retire_buffer_pkg::*;
#(
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2,
  parameter int DEPTH     = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             push_en,
  input  logic [IN_WIDTH-1:0]              push_valid,
  input  logic [IN_WIDTH*RT_ENTRY_W-1:0]   push_data,
  input  logic [$clog2(DEPTH):0]           pop_cnt,
  input  logic                             flush,
  output logic [OUT_WIDTH*RT_ENTRY_W-1:0]  head_data,
  output logic [$clog2(DEPTH):0]           count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  RT_ENTRY          mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] slot_off_s [IN_WIDTH];
  logic [CNT_W-1:0] push_cnt_s;

  // Each accepted slot lands right after the accepted slots older than it.
  always_comb begin
    push_cnt_s = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      slot_off_s[i] = push_cnt_s[PTR_W-1:0];
      if (push_en && push_valid[i]) begin
        push_cnt_s = push_cnt_s + CNT_W'(1);
      end else begin
        push_cnt_s = push_cnt_s;
      end
    end
  end

  // Entry storage; a flush wins over a same-cycle push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < DEPTH; d++) begin
        mem_r[d] <= '0;
      end
    end else if (!flush) begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (push_en && push_valid[i]) begin
          mem_r[tail_r + slot_off_s[i]] <= push_data[i*RT_ENTRY_W +: RT_ENTRY_W];
        end
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_r + pop_cnt[PTR_W-1:0];
      tail_r  <= tail_r + push_cnt_s[PTR_W-1:0];
      count_r <= count_r + push_cnt_s - pop_cnt;
    end
  end

  // Oldest entries presented in port order.
  always_comb begin
    head_data = '0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      head_data[k*RT_ENTRY_W +: RT_ENTRY_W] = mem_r[head_r + PTR_W'(k)];
    end
  end

  assign count = count_r;

endmodule

// File: rtl/retire_buffer.sv
// Retire stage between ROB and regfile: queues retired entries, drains them onto
// registered write ports with same-group WAW suppression, halt and retire count.
module retire_buffer
  import retire_buffer_pkg::*;
#(
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2,
  parameter int DEPTH     = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [IN_WIDTH-1:0]             rob_rt_valid,
  input  logic [IN_WIDTH*RT_PACKET_W-1:0] rob_rt_packet,
  input  logic [IN_WIDTH-1:0]             rob_rt_halt,
  output logic                            rt_ready,
  output logic [OUT_WIDTH-1:0]            wb_regfile_en,
  output logic [OUT_WIDTH*5-1:0]          wb_regfile_idx,
  output logic [OUT_WIDTH*XLEN-1:0]       wb_regfile_data,
  output logic                            halted,
  output logic [63:0]                     instr_retired,
  output logic [$clog2(DEPTH):0]          occupancy
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int OUT_CAP = (OUT_WIDTH > DEPTH) ? DEPTH : OUT_WIDTH;

  logic [IN_WIDTH*RT_ENTRY_W-1:0]  push_data_s;
  logic [OUT_WIDTH*RT_ENTRY_W-1:0] head_data_s;
  RT_ENTRY                         head_s [OUT_WIDTH];
  logic [CNT_W-1:0]                count_s;
  logic [CNT_W-1:0]                pop_cnt_s;
  logic                            rt_ready_s;
  logic [OUT_WIDTH-1:0]            popped_s;
  logic [OUT_WIDTH-1:0]            live_s;
  logic [OUT_WIDTH-1:0]            sup_s;
  logic [OUT_WIDTH-1:0]            wen_s;
  logic                            halt_hit_s;
  logic                            blocked_s;
  logic [7:0]                      retired_cnt_s;
  logic [64:0]                     retired_sum_s;
  logic [63:0]                     retired_next_s;

  logic                            halted_r;
  logic [63:0]                     retired_r;
  logic [OUT_WIDTH-1:0]            en_r;
  logic [OUT_WIDTH*5-1:0]          idx_r;
  logic [OUT_WIDTH*XLEN-1:0]       data_r;

  // Repack ROB slots into queue entries.
  always_comb begin
    push_data_s = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      ROB_RT_PACKET pkt;
      RT_ENTRY      ent;
      pkt      = rob_rt_packet[i*RT_PACKET_W +: RT_PACKET_W];
      ent.r    = pkt.data_retired.r;
      ent.V    = pkt.data_retired.V;
      ent.halt = rob_rt_halt[i];
      push_data_s[i*RT_ENTRY_W +: RT_ENTRY_W] = ent;
    end
  end

  assign rt_ready_s = ((CNT_W'(DEPTH) - count_s) >= CNT_W'(IN_WIDTH)) && !halted_r;

  retire_fifo #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_en    (rt_ready_s),
    .push_valid (rob_rt_valid),
    .push_data  (push_data_s),
    .pop_cnt    (pop_cnt_s),
    .flush      (halt_hit_s),
    .head_data  (head_data_s),
    .count      (count_s)
  );

  // Drain group: how many leave, which are live (not behind a halt), and the count.
  always_comb begin
    if (halted_r) begin
      pop_cnt_s = '0;
    end else if (count_s >= CNT_W'(OUT_CAP)) begin
      pop_cnt_s = CNT_W'(OUT_CAP);
    end else begin
      pop_cnt_s = count_s;
    end
    blocked_s     = 1'b0;
    halt_hit_s    = 1'b0;
    retired_cnt_s = 8'd0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      head_s[k]   = head_data_s[k*RT_ENTRY_W +: RT_ENTRY_W];
      popped_s[k] = (CNT_W'(k) < pop_cnt_s);
      live_s[k]   = popped_s[k] && !blocked_s;
      if (live_s[k]) begin
        retired_cnt_s = retired_cnt_s + 8'd1;
      end else begin
        retired_cnt_s = retired_cnt_s;
      end
      if (live_s[k] && head_s[k].halt) begin
        halt_hit_s = 1'b1;
        blocked_s  = 1'b1;
      end else begin
        halt_hit_s = halt_hit_s;
        blocked_s  = blocked_s;
      end
    end
  end

  // An older write loses to any younger live write of the same register.
  always_comb begin
    sup_s = '0;
    wen_s = '0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      for (int j = k + 1; j < OUT_WIDTH; j++) begin
        if (live_s[j] && writes_reg(head_s[j]) && (head_s[j].r == head_s[k].r)) begin
          sup_s[k] = 1'b1;
        end else begin
          sup_s[k] = sup_s[k];
        end
      end
      wen_s[k] = live_s[k] && writes_reg(head_s[k]) && !sup_s[k];
    end
  end

  always_comb begin
    retired_sum_s = {1'b0, retired_r} + 65'(retired_cnt_s);
    if (retired_sum_s[64]) begin
      retired_next_s = '1;
    end else begin
      retired_next_s = retired_sum_s[63:0];
    end
  end

  // Write ports: enables every cycle; idx/data hold unless that port drained an entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_r   <= '0;
      idx_r  <= '0;
      data_r <= '0;
    end else begin
      en_r <= wen_s;
      for (int k = 0; k < OUT_WIDTH; k++) begin
        if (popped_s[k]) begin
          idx_r[k*5 +: 5]        <= head_s[k].r;
          data_r[k*XLEN +: XLEN] <= head_s[k].V;
        end
      end
    end
  end

  // Sticky halt and saturating retire counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      halted_r  <= 1'b0;
      retired_r <= 64'd0;
    end else begin
      if (halt_hit_s) begin
        halted_r <= 1'b1;
      end
      retired_r <= retired_next_s;
    end
  end

  assign rt_ready        = rt_ready_s;
  assign wb_regfile_en   = en_r;
  assign wb_regfile_idx  = idx_r;
  assign wb_regfile_data = data_r;
  assign halted          = halted_r;
  assign instr_retired   = retired_r;
  assign occupancy       = count_s;

endmodule
